// File: rtl/dmem_rmw_bridge.sv
// Data-memory responder bridge: serves byte-lane requests from the core out of a
// word-wide synchronous SRAM without byte enables. Full-word writes pass straight
// through; partial writes are read-modify-write. Reads return the full word.
module dmem_rmw_bridge #(
  parameter int XLEN   = 32,
  parameter int AWIDTH = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [3:0]        req_we,
  input  logic              req_re,
  output logic              busy,
  output logic [XLEN-1:0]   rdata,
  output logic              rvalid,
  output logic [AWIDTH-3:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int WAW = AWIDTH - 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_DATA  = 3'd2,
    S_WR       = 3'd3,
    S_RMW_RD   = 3'd4,
    S_RMW_MRG  = 3'd5
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [WAW-1:0]  addr_r;
  logic [XLEN-1:0] wdata_r;
  logic [3:0]      we_r;
  logic            re_r;
  logic [XLEN-1:0] merge_r;
  logic [XLEN-1:0] rdata_r;
  logic            rvalid_r;
  logic            capture_s;

  // Low address bits select a lane only through req_we, and the captured read
  // flag never steers anything because the branch is decided at capture time.
  logic unused_s;
  assign unused_s = ^{req_addr[1:0], re_r};

  // Replace the lanes selected by we with the new write data, keep the rest.
  function automatic logic [XLEN-1:0] merge_lanes(
    input logic [3:0]      we,
    input logic [XLEN-1:0] wd,
    input logic [XLEN-1:0] rd
  );
    logic [XLEN-1:0] m;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        m[8*i +: 8] = wd[8*i +: 8];
      end else begin
        m[8*i +: 8] = rd[8*i +: 8];
      end
    end
    return m;
  endfunction

  assign capture_s = (state_r == S_IDLE) && req_valid;

  // State register; reset aborts any operation in flight, including an RMW.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; a write request wins over a simultaneous read.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (!req_valid) begin
          state_s = S_IDLE;
        end else if (req_we == 4'hF) begin
          state_s = S_WR;
        end else if (req_we != 4'h0) begin
          state_s = S_RMW_RD;
        end else if (req_re) begin
          state_s = S_RD_ISSUE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RD_ISSUE: state_s = S_RD_DATA;
      S_RD_DATA:  state_s = S_IDLE;
      S_WR:       state_s = S_IDLE;
      S_RMW_RD:   state_s = S_RMW_MRG;
      S_RMW_MRG:  state_s = S_WR;
      default:    state_s = S_IDLE;
    endcase
  end

  // Request capture; only taken while idle so requests during busy are dropped.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      addr_r  <= {WAW{1'b0}};
      wdata_r <= {XLEN{1'b0}};
      we_r    <= 4'h0;
      re_r    <= 1'b0;
    end else if (capture_s) begin
      addr_r  <= req_addr[AWIDTH-1:2];
      wdata_r <= req_wdata;
      we_r    <= req_we;
      re_r    <= req_re;
    end else begin
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      we_r    <= we_r;
      re_r    <= re_r;
    end
  end

  // Merge register: SRAM word arrives the cycle after the RMW read strobe.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      merge_r <= {XLEN{1'b0}};
    end else if (state_r == S_RMW_MRG) begin
      merge_r <= merge_lanes(we_r, wdata_r, mem_rdata);
    end else begin
      merge_r <= merge_r;
    end
  end

  // Read return: rdata holds until the next read, rvalid is a one-cycle pulse.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rdata_r  <= {XLEN{1'b0}};
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= (state_r == S_RD_DATA);
      if (state_r == S_RD_DATA) begin
        rdata_r <= mem_rdata;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  // Memory-side strobes decode from state and captured registers only.
  always_comb begin
    busy      = (state_r != S_IDLE);
    mem_addr  = addr_r;
    mem_re    = (state_r == S_RD_ISSUE) || (state_r == S_RMW_RD);
    mem_we    = (state_r == S_WR);
    mem_wdata = {XLEN{1'b0}};
    if (state_r == S_WR) begin
      if (we_r == 4'hF) begin
        mem_wdata = wdata_r;
      end else begin
        mem_wdata = merge_r;
      end
    end else begin
      mem_wdata = {XLEN{1'b0}};
    end
  end

  assign rdata  = rdata_r;
  assign rvalid = rvalid_r;

endmodule

// File: tb/tb_dmem_rmw_bridge.sv
// Directed bench for dmem_rmw_bridge with a synchronous word SRAM model.
module tb_dmem_rmw_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic [17:0] req_addr = 18'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_we = 4'h0;
  logic        req_re = 1'b0;
  logic        busy;
  logic [31:0] rdata;
  logic        rvalid;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] mem [0:65535];
  logic        pre_en = 1'b0;
  logic [15:0] pre_addr = 16'h0;
  logic [31:0] pre_data = 32'h0;

  int checks = 0;
  int errs = 0;

  typedef struct {
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        re;
    int          exp_busy;
    int          exp_we;
    int          exp_re;
    int          exp_rv;
    logic [15:0] word;
    logic [31:0] exp_word;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  dmem_rmw_bridge #(.XLEN(32), .AWIDTH(18)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .req_re(req_re), .busy(busy),
    .rdata(rdata), .rvalid(rvalid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM: write on mem_we, read data valid the cycle after mem_re.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic drive(input logic [17:0] a, input logic [31:0] d, input logic [3:0] we, input logic re);
    req_valid = 1'b1; req_addr = a; req_wdata = d; req_we = we; req_re = re;
  endtask

  // Issue one request and observe six cycles of activity.
  task automatic run_vec(input int idx, input vec_t v);
    int busy_n = 0, we_n = 0, re_n = 0, rv_n = 0, bad_addr = 0;
    logic [31:0] rd = 32'h0;
    @(negedge clk);
    drive(v.addr, v.wdata, v.we, v.re);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (busy) busy_n++;
      if (mem_we) begin we_n++; if (mem_addr != v.word) bad_addr++; end
      if (mem_re) begin re_n++; if (mem_addr != v.word) bad_addr++; end
      if (rvalid) begin rv_n++; rd = rdata; end
    end
    chk($sformatf("v%0d busy_cycles", idx), busy_n, v.exp_busy);
    chk($sformatf("v%0d mem_we_pulses", idx), we_n, v.exp_we);
    chk($sformatf("v%0d mem_re_pulses", idx), re_n, v.exp_re);
    chk($sformatf("v%0d rvalid_pulses", idx), rv_n, v.exp_rv);
    chk($sformatf("v%0d strobe_addr_errs", idx), bad_addr, 32'd0);
    chk($sformatf("v%0d mem_word", idx), mem[v.word], v.exp_word);
    if (v.exp_rv != 0) chk($sformatf("v%0d rdata", idx), rd, v.exp_rdata);
  endtask

  initial begin
    int we_n;
    //          addr      wdata          we    re    bsy we re rv word     exp_word       exp_rdata
    vecs[0]  = '{18'h00008, 32'hDEADBEEF, 4'hF, 1'b0, 1, 1, 0, 0, 16'h0002, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{18'h00008, 32'h00000000, 4'h0, 1'b1, 2, 0, 1, 1, 16'h0002, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{18'h00001, 32'h00005500, 4'h2, 1'b0, 3, 1, 1, 0, 16'h0000, 32'h11225544, 32'h0};
    vecs[3]  = '{18'h00016, 32'hAAAA0000, 4'hC, 1'b0, 3, 1, 1, 0, 16'h0005, 32'hAAAAFFFF, 32'h0};
    vecs[4]  = '{18'h00016, 32'h00000000, 4'h0, 1'b1, 2, 0, 1, 1, 16'h0005, 32'hAAAAFFFF, 32'hAAAAFFFF};
    vecs[5]  = '{18'h00020, 32'h12345678, 4'h0, 1'b0, 0, 0, 0, 0, 16'h0000, 32'h11225544, 32'h0};
    vecs[6]  = '{18'h3FFFC, 32'h12345678, 4'hF, 1'b1, 1, 1, 0, 0, 16'hFFFF, 32'h12345678, 32'h0};
    vecs[7]  = '{18'h3FFFF, 32'h00000000, 4'h0, 1'b1, 2, 0, 1, 1, 16'hFFFF, 32'h12345678, 32'h12345678};
    vecs[8]  = '{18'h0000B, 32'h000000A5, 4'h1, 1'b0, 3, 1, 1, 0, 16'h0002, 32'hDEADBEA5, 32'h0};
    vecs[9]  = '{18'h00008, 32'h770000CC, 4'h9, 1'b0, 3, 1, 1, 0, 16'h0002, 32'h77ADBECC, 32'h0};
    vecs[10] = '{18'h00009, 32'h00000000, 4'h0, 1'b1, 2, 0, 1, 1, 16'h0002, 32'h77ADBECC, 32'h77ADBECC};

    // Preload while reset is held (active-high).
    preload(16'h0000, 32'h11223344);
    preload(16'h0002, 32'h00000000);
    preload(16'h0003, 32'hCAFEF00D);
    preload(16'h0005, 32'hFFFFFFFF);
    preload(16'h0007, 32'h00000000);
    preload(16'h0009, 32'h00000000);
    preload(16'hFFFF, 32'h00000000);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset busy", busy, 32'd0);
    chk("reset rvalid", rvalid, 32'd0);
    chk("reset mem_we", mem_we, 32'd0);
    chk("reset mem_re", mem_re, 32'd0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Requests arriving while an RMW is busy must be dropped.
    @(negedge clk);
    drive(18'h00002, 32'h00660000, 4'h4, 1'b0);
    we_n = 0;
    @(negedge clk);
    drive(18'h0001C, 32'h00000BAD, 4'hF, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      if (c == 4) req_valid = 1'b0;
      if (mem_we) we_n++;
      @(negedge clk);
    end
    chk("busy_ignore we_pulses", we_n, 32'd1);
    chk("busy_ignore word0", mem[0], 32'h11665544);
    chk("busy_ignore word7", mem[7], 32'h00000000);

    // Back-to-back: new request accepted in the cycle rvalid is high.
    @(negedge clk);
    drive(18'h00014, 32'h0, 4'h0, 1'b1);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b2b rvalid", rvalid, 32'd1);
    chk("b2b rdata", rdata, 32'hAAAAFFFF);
    drive(18'h00024, 32'h0BADF00D, 4'hF, 1'b0);
    @(negedge clk); req_valid = 1'b0;
    chk("b2b busy", busy, 32'd1);
    chk("b2b mem_we", mem_we, 32'd1);
    chk("b2b mem_addr", mem_addr, 32'd9);
    @(negedge clk);
    chk("b2b word9", mem[9], 32'h0BADF00D);

    // Reset asserted in RMW_MRG aborts the write.
    @(negedge clk);
    drive(18'h0000C, 32'h00000011, 4'h1, 1'b0);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mrg busy", busy, 32'd0);
    chk("rst_mrg mem_we", mem_we, 32'd0);
    chk("rst_mrg rdata", rdata, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mrg word3", mem[3], 32'hCAFEF00D);

    // Reset asserted in WR of an RMW drops mem_we at once and writes nothing.
    drive(18'h0000C, 32'h00000022, 4'h1, 1'b0);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_wr pre mem_we", mem_we, 32'd1);
    rst_n = 1'b1;
    #1;
    chk("rst_wr mem_we", mem_we, 32'd0);
    chk("rst_wr busy", busy, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_wr word3", mem[3], 32'hCAFEF00D);

    // A full write after reset release completes normally.
    drive(18'h0000C, 32'h55AA55AA, 4'hF, 1'b0);
    @(negedge clk); req_valid = 1'b0;
    chk("post_rst mem_we", mem_we, 32'd1);
    @(negedge clk);
    chk("post_rst word3", mem[3], 32'h55AA55AA);
    chk("post_rst busy", busy, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
